bsg_dlatch_capture_fifo: RTL and testbench
==========================================

# bsg_dlatch_capture_fifo

Clocked capture stage that sits directly downstream of a 32-bit transparent latch bank. On a one-cycle capture strobe it samples the latch output on the rising edge of `clk_i`, when the latch output is settled. It then queues the sample in a small FIFO and presents it to the consumer through a valid/yumi handshake. When the FIFO is full it drops captures and counts the drops, so upstream capture timing never stalls.

## Interface
Parameters:
- `width_p`, 32, data width; must match the latch bank width.
- `els_p`, 4, FIFO depth; power of two, 2..16.
- `drop_cnt_width_p`, 8, width of the saturating drop counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; synchronous, active-low.
- `data_i`  in  `width_p`  latch output; sampled only on edges where `capture_i`=1.
- `capture_i`  in  1  request to sample `data_i` on this edge.
- `v_o`  out  1  FIFO non-empty; `data_o` is valid.
- `data_o`  out  `width_p`  oldest queued sample.
- `yumi_i`  in  1  consumer takes `data_o` this cycle; legal only when `v_o`=1.
- `full_o`  out  1  FIFO holds `els_p` entries.
- `count_o`  out  `$clog2(els_p+1)`  number of queued entries.
- `drop_cnt_o`  out  `drop_cnt_width_p`  captures lost to full; saturates.

## Operation
- Storage: `els_p` x `width_p` register array, a read pointer and a write pointer (each `$clog2(els_p)` bits, wrapping modulo `els_p`), and an entry counter `count_o`. All outputs are registered or derived from registered state only; there is no combinational path from input to output.
- Enqueue condition `enq` = `capture_i` & (~`full_o` | `yumi_i`).
  - When `enq`=1: write `data_i` at `wptr`, then `wptr`++.
  - A capture while full is accepted when a yumi occurs on the same edge, because the slot is freed that cycle.
- Dequeue condition `deq` = `yumi_i` & `v_o`: `rptr`++.
  - `yumi_i` while `v_o`=0 is illegal. The design ignores it: no pointer or count change. The bench flags it with an assertion.
- Count update: `count` += `enq` − `deq`.
  - `v_o` = (`count` != 0).
  - `full_o` = (`count` == `els_p`).
- Drop condition `drop` = `capture_i` & `full_o` & ~`yumi_i`. On `drop`, `drop_cnt_o` increments, saturating at 2^`drop_cnt_width_p`−1. The dropped sample is discarded and queued data is unaffected.
- Empty FIFO with simultaneous `capture_i` and `yumi_i`: `yumi_i` is illegal (`v_o`=0) and is ignored. The capture enqueues normally.
- Wrap-around: pointers roll from `els_p`−1 to 0 with no bubble. FIFO order is preserved across the wrap.

## Timing
- Reset: when `reset_n_i`=0 on a rising edge, the following clear on that edge:
  - `rptr`, `wptr`, `count` → 0
  - `v_o` → 0, `full_o` → 0, `count_o` → 0, `drop_cnt_o` → 0
- Reset dominates any `capture_i` or `yumi_i` on the same edge, including mid-operation. All queued entries are discarded.
- The storage array is not reset. `data_o` is undefined whenever `v_o`=0 and must not be checked then.
- Capture-to-output latency is 1 cycle: a capture on edge N into an empty FIFO gives `v_o`=1 and `data_o`=sample after edge N.
- Throughput: one enqueue and one dequeue per cycle sustained. With `capture_i`=`yumi_i`=1 every cycle, `count_o` stays constant.
- After a dequeue on edge N, `data_o` shows the next entry after edge N, or `v_o` drops to 0 if that was the last entry.
- `full_o`, `count_o` and `drop_cnt_o` reflect the state after the most recent edge.

## Test plan
- Reset, then capture 0xA5A5_0001 for one cycle with `yumi_i`=0 → next cycle `v_o`=1, `data_o`=0xA5A5_0001, `count_o`=1; a yumi then gives `v_o`=0, `count_o`=0.
- Capture 6 values 0x10..0x15 back to back with no yumi, `els_p`=4 → `full_o`=1 after the 4th; `drop_cnt_o`=2; draining yields 0x10, 0x11, 0x12, 0x13 in order.
- Full FIFO, `capture_i`=`yumi_i`=1 with 0x99 → `drop_cnt_o` unchanged, `count_o` stays 4, 0x99 appears after the three remaining older entries.
- Stream 1000 captures with continuous yumi (pointer wrap many times) → output sequence equals input sequence, `drop_cnt_o`=0; force 300 drops with `drop_cnt_width_p`=8 → `drop_cnt_o`=255.
- `reset_n_i`=0 for one edge while `count_o`=3 and `capture_i`=`yumi_i`=1 → after the edge `v_o`=0, `count_o`=0, `full_o`=0, `drop_cnt_o`=0; the next capture appears alone at the output.

Source files
------------

// File: rtl/bsg_dlatch_capture_fifo.sv
// Capture stage behind a transparent latch bank. A one-cycle capture strobe
// samples the settled latch output on the rising clock edge and queues it in a
// small FIFO. The consumer drains the FIFO through a valid/yumi handshake.
// When the FIFO is full, captures are dropped and counted, so upstream capture
// timing never stalls.
//
// Handshake: v_o=1 means data_o holds the oldest queued sample. The consumer
// raises yumi_i in the same cycle to take it, and that entry is removed on the
// next rising edge. yumi_i is only legal while v_o=1. A stray yumi_i while
// v_o=0 is ignored.
module bsg_dlatch_capture_fifo #(
    parameter int width_p          = 32,
    parameter int els_p            = 4,
    parameter int drop_cnt_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [width_p-1:0]            data_i,
    input  logic                          capture_i,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          yumi_i,
    output logic                          full_o,
    output logic [$clog2(els_p+1)-1:0]    count_o,
    output logic [drop_cnt_width_p-1:0]   drop_cnt_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);

    logic [width_p-1:0]          mem [els_p];
    logic [ptr_w-1:0]            rptr;
    logic [ptr_w-1:0]            wptr;
    logic [cnt_w-1:0]            count;
    logic [drop_cnt_width_p-1:0] drop_cnt;

    logic full;
    logic empty;
    logic enq;
    logic deq;
    logic drop;

    // Status flags and the handshake decisions, all derived from registered
    // count plus the current strobes. A yumi frees a slot on the same edge, so
    // a capture while full is still accepted if a yumi accompanies it.
    always_comb begin
        full  = (count == cnt_w'(els_p));
        empty = (count == '0);
        deq   = yumi_i & ~empty;
        enq   = capture_i & (~full | yumi_i);
        drop  = capture_i & full & ~yumi_i;
    end

    // Pointer and occupancy bookkeeping. Depth is a power of two, so the
    // pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + ptr_w'(1);
            if (deq) rptr <= rptr + ptr_w'(1);
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample storage. It is not reset, because entries past count are never
    // observed.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

    // Saturating count of captures lost to a full FIFO.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + drop_cnt_width_p'(1);
        end
    end

    // Outputs come only from registered state.
    always_comb begin
        v_o        = ~empty;
        full_o     = full;
        count_o    = count;
        drop_cnt_o = drop_cnt;
        data_o     = mem[rptr];
    end

endmodule

// File: tb/tb_bsg_dlatch_capture_fifo.sv
// Bench for bsg_dlatch_capture_fifo. The reference model is a plain queue of
// accepted samples plus a saturating integer drop count.
module tb_bsg_dlatch_capture_fifo;

  localparam int W   = 32;
  localparam int ELS = 4;
  localparam int DW  = 8;
  localparam int CW  = $clog2(ELS+1);
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk;
  logic          reset_n_i;
  logic [W-1:0]  data_i;
  logic          capture_i;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic [DW-1:0] drop_cnt_o;

  logic [W-1:0] exp_q[$];
  int           exp_drops;
  int           checks;
  int           errors;

  bsg_dlatch_capture_fifo #(
    .width_p(W), .els_p(ELS), .drop_cnt_width_p(DW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .capture_i(capture_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .full_o(full_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // yumi while the FIFO is empty is a protocol violation
  always @(posedge clk) begin
    if (reset_n_i === 1'b1 && yumi_i === 1'b1)
      assert (v_o === 1'b1) else $error("illegal yumi while v_o=0");
  end

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare registered status against the model (called #1 after an edge)
  task automatic check_state();
    check_val("count_o", count_o, exp_q.size());
    check_val("full_o", full_o, exp_q.size() == ELS);
    check_val("v_o", v_o, exp_q.size() != 0);
    check_val("drop_cnt_o", drop_cnt_o, exp_drops);
  endtask

  // drive one cycle, update the model, advance past the next rising edge
  task automatic step(input bit rst, input bit cap, input logic [W-1:0] d, input bit y);
    bit ylegal;
    check_state();
    ylegal    = y && (exp_q.size() > 0);
    reset_n_i = !rst;
    capture_i = cap;
    data_i    = d;
    yumi_i    = ylegal;
    if (rst) begin
      exp_q.delete();
      exp_drops = 0;
    end else if (cap) begin
      if (exp_q.size() < ELS || ylegal) exp_q.push_back(d);
      else if (exp_drops < DROP_MAX) exp_drops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step(0, 0, '0, 1);
  endtask

  // scoreboard monitor: every accepted yumi must deliver the oldest expected sample
  always @(negedge clk) begin
    if (reset_n_i === 1'b1 && yumi_i === 1'b1 && v_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_o: got %0h with no sample expected at %0t", data_o, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL data_o: got %0h expected %0h at %0t", data_o, e, $time);
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; exp_drops = 0;
    reset_n_i = 1'b0; capture_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // single capture, 1-cycle latency, then consume
    step(0, 1, 32'hA5A5_0001, 0);
    check_val("single_data", data_o, 32'hA5A5_0001);
    step(0, 0, '0, 1);

    // overflow: six back-to-back captures into depth four
    for (int i = 0; i < 6; i++) step(0, 1, W'(32'h10 + i), 0);
    check_val("overflow_drops", drop_cnt_o, 2);
    drain();

    // full FIFO with capture and yumi together: accepted, no drop
    for (int i = 0; i < 4; i++) step(0, 1, W'(32'h20 + i), 0);
    step(0, 1, 32'h99, 1);
    check_val("full_swap_count", count_o, 4);
    drain();

    // long stream with continuous yumi: many pointer wraps
    for (int i = 0; i < 1000; i++) step(0, 1, W'($urandom), 1);
    drain();

    // saturate the drop counter
    for (int i = 0; i < 304; i++) step(0, 1, W'($urandom), 0);
    check_val("drop_saturate", drop_cnt_o, DROP_MAX);
    drain();

    // reset mid-operation with capture and yumi asserted
    for (int i = 0; i < 3; i++) step(0, 1, W'(32'h40 + i), 0);
    step(1, 1, 32'hDEAD, 1);
    check_val("reset_count", count_o, 0);
    step(0, 1, 32'h55, 0);
    check_val("post_reset_data", data_o, 32'h55);
    drain();

    // random mix with occasional resets
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 2) != 0);
    drain();
    step(0, 0, '0, 0);
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
